// File: rtl/bcd_score_engine.sv
// BCD score/high-score keeper: signed BCD deltas are applied digit-serially, one digit per clock.
// Latency NUM_DIGITS+2 cycles per op; op_ready stays low from accept until the commit cycle completes.
module bcd_score_engine #(
    parameter int NUM_DIGITS = 3,
    parameter bit SATURATE   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    clear_high,
    input  logic                    op_valid,
    input  logic                    op_sub,
    input  logic [3:0]              op_delta,
    output logic                    op_ready,
    output logic [4*NUM_DIGITS-1:0] score_bcd,
    output logic [4*NUM_DIGITS-1:0] high_bcd,
    output logic                    new_high,
    output logic                    ovf
);

    localparam int W  = 4 * NUM_DIGITS;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IW-1:0] LAST  = IW'(NUM_DIGITS - 1);
    localparam logic [W-1:0]  NINES = {NUM_DIGITS{4'h9}};

    typedef enum logic [1:0] {IDLE, DIGIT, COMMIT} state_t;

    state_t         state, state_nxt;
    logic [IW-1:0]  idx;
    logic           carry;
    logic [W-1:0]   work;
    logic           sub_q;
    logic [3:0]     delta_q;
    logic           accept;

    logic [3:0]     cur, addend, dig_res;
    logic [4:0]     sum, need;
    logic           carry_res;
    logic [W-1:0]   committed;

    always_comb begin
        state_nxt = state;
        op_ready  = (state == IDLE) && !clear;
        accept    = op_valid && op_ready;
        case (state)
            IDLE:    if (accept) state_nxt = DIGIT;
            DIGIT:   if (idx == LAST) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (clear) state_nxt = IDLE;
    end

    // One digit of the add/subtract; carry doubles as borrow when sub_q is set.
    always_comb begin
        cur = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) cur = work[4*i +: 4];
        end
        addend    = (idx == '0) ? delta_q : 4'd0;
        sum       = {1'b0, cur} + {1'b0, addend} + {4'd0, carry};
        need      = {1'b0, addend} + {4'd0, carry};
        dig_res   = 4'd0;
        carry_res = 1'b0;
        if (!sub_q) begin
            if (sum > 5'd9) begin
                dig_res   = 4'(sum - 5'd10);
                carry_res = 1'b1;
            end else begin
                dig_res = sum[3:0];
            end
        end else begin
            if ({1'b0, cur} >= need) begin
                dig_res = 4'({1'b0, cur} - need);
            end else begin
                dig_res   = 4'({1'b0, cur} + 5'd10 - need);
                carry_res = 1'b1;
            end
        end
    end

    always_comb begin
        committed = work;
        if (carry && SATURATE) committed = sub_q ? '0 : NINES;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            work      <= '0;
            sub_q     <= 1'b0;
            delta_q   <= 4'd0;
            score_bcd <= '0;
            high_bcd  <= '0;
            new_high  <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            new_high <= 1'b0;
            state    <= state_nxt;
            if (clear_high) high_bcd <= '0;
            if (clear) begin
                score_bcd <= '0;
                ovf       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            sub_q   <= op_sub;
                            delta_q <= (op_delta > 4'd9) ? 4'd9 : op_delta;
                            work    <= score_bcd;
                            idx     <= '0;
                            carry   <= 1'b0;
                        end
                    end
                    DIGIT: begin
                        for (int i = 0; i < NUM_DIGITS; i++) begin
                            if (idx == IW'(i)) work[4*i +: 4] <= dig_res;
                        end
                        carry <= carry_res;
                        idx   <= idx + IW'(1);
                    end
                    COMMIT: begin
                        score_bcd <= committed;
                        if (carry && !sub_q) ovf <= 1'b1;
                        // A concurrent clear_high wins over a new record.
                        if (!clear_high && (committed > high_bcd)) begin
                            high_bcd <= committed;
                            new_high <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bcd_score_engine.sv
// Bench for bcd_score_engine: a saturating and a wrapping instance share stimulus, checked against tables and an integer model.
module tb_bcd_score_engine;

    localparam int N    = 3;
    localparam int W    = 4 * N;
    localparam int MAXV = 10 ** N - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0, clear = 1'b0, clear_high = 1'b0;
    logic op_valid = 1'b0, op_sub = 1'b0;
    logic [3:0] op_delta = 4'd0;
    logic rdy_s, rdy_w, nh_s, nh_w, ovf_s, ovf_w;
    logic [W-1:0] sc_s, sc_w, hi_s, hi_w;

    always #5 clk = ~clk;

    bcd_score_engine #(.NUM_DIGITS(N), .SATURATE(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .clear(clear), .clear_high(clear_high),
        .op_valid(op_valid), .op_sub(op_sub), .op_delta(op_delta), .op_ready(rdy_s),
        .score_bcd(sc_s), .high_bcd(hi_s), .new_high(nh_s), .ovf(ovf_s));

    bcd_score_engine #(.NUM_DIGITS(N), .SATURATE(1'b0)) dut_w (
        .clk(clk), .rst_n(rst_n), .clear(clear), .clear_high(clear_high),
        .op_valid(op_valid), .op_sub(op_sub), .op_delta(op_delta), .op_ready(rdy_w),
        .score_bcd(sc_w), .high_bcd(hi_w), .new_high(nh_w), .ovf(ovf_w));

    int n_cmp = 0, n_bad = 0;
    int m_sc[2], m_hi[2];
    bit m_ov[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] int2bcd(input int v);
        logic [W-1:0] b;
        int x;
        x = v;
        b = '0;
        for (int i = 0; i < N; i++) begin
            b[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return b;
    endfunction

    task automatic check_state(input string tag);
        check({tag, "_score_sat"},  32'(sc_s),  32'(int2bcd(m_sc[0])));
        check({tag, "_score_wrap"}, 32'(sc_w),  32'(int2bcd(m_sc[1])));
        check({tag, "_high_sat"},   32'(hi_s),  32'(int2bcd(m_hi[0])));
        check({tag, "_high_wrap"},  32'(hi_w),  32'(int2bcd(m_hi[1])));
        check({tag, "_ovf"},        {ovf_s, ovf_w}, {m_ov[0], m_ov[1]});
    endtask

    // Drive one op (clear_high held at ch throughout), check timing, then the model result.
    task automatic do_op(input bit sub, input logic [3:0] d, input bit ch, output bit seen_s, output bit seen_w);
        int lowc, v, dd;
        bit hold_ok, early_nh;
        bit enh[2];
        logic [W-1:0] pre_s, pre_w;
        @(negedge clk);
        check("ready_before", {rdy_s, rdy_w}, 2'b11);
        clear_high = ch; op_valid = 1'b1; op_sub = sub; op_delta = d;
        pre_s = sc_s; pre_w = sc_w;
        @(posedge clk);
        #1 op_valid = 1'b0;
        lowc = 0; hold_ok = 1'b1; early_nh = 1'b0;
        while (lowc < 20) begin
            @(negedge clk);
            if (rdy_s && rdy_w) break;
            lowc++;
            if (sc_s !== pre_s || sc_w !== pre_w) hold_ok = 1'b0;
            if (nh_s || nh_w) early_nh = 1'b1;
        end
        check("ready_low_cycles", lowc, N + 1);
        check("score_hold", 32'(hold_ok), 32'd1);
        check("no_early_new_high", 32'(early_nh), 32'd0);
        seen_s = nh_s; seen_w = nh_w;
        clear_high = 1'b0;
        dd = (d > 9) ? 9 : int'(d);
        for (int k = 0; k < 2; k++) begin
            v = sub ? m_sc[k] - dd : m_sc[k] + dd;
            if (v > MAXV) begin
                m_ov[k] = 1'b1;
                m_sc[k] = (k == 0) ? MAXV : v - (MAXV + 1);
            end else if (v < 0) begin
                m_sc[k] = (k == 0) ? 0 : v + MAXV + 1;
            end else begin
                m_sc[k] = v;
            end
            enh[k] = 1'b0;
            if (ch) m_hi[k] = 0;
            else if (m_sc[k] > m_hi[k]) begin
                m_hi[k] = m_sc[k];
                enh[k]  = 1'b1;
            end
        end
        check("new_high", {seen_s, seen_w}, {enh[0], enh[1]});
        check_state("op");
        @(negedge clk);
        check("new_high_one_cycle", {nh_s, nh_w}, 2'b00);
    endtask

    task automatic do_clear(input bit c, input bit ch);
        @(negedge clk);
        clear = c; clear_high = ch;
        #1;
        if (c) check("ready_in_clear", {rdy_s, rdy_w}, 2'b00);
        @(posedge clk);
        #1 clear = 1'b0; clear_high = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (c) begin m_sc[k] = 0; m_ov[k] = 1'b0; end
            if (ch) m_hi[k] = 0;
        end
        @(negedge clk);
        check_state("clear");
    endtask

    task automatic preset(input int target);
        bit a, b;
        int step;
        do_clear(1'b1, 1'b0);
        while (m_sc[0] < target) begin
            step = (target - m_sc[0] > 9) ? 9 : target - m_sc[0];
            do_op(1'b0, 4'(step), 1'b0, a, b);
        end
    endtask

    typedef struct {
        int         pre;
        bit         sub;
        logic [3:0] d;
        int         exp_s, exp_w;
        bit         ov_s, ov_w, nh_s, nh_w;
    } vec_t;

    vec_t tbl[8];

    initial begin
        bit a, b;
        bit bad;
        m_sc = '{0, 0}; m_hi = '{0, 0}; m_ov = '{1'b0, 1'b0};

        tbl[0] = '{-1,  1'b0, 4'd1,  1,   1,   1'b0, 1'b0, 1'b1, 1'b1};
        tbl[1] = '{-1,  1'b0, 4'd1,  2,   2,   1'b0, 1'b0, 1'b1, 1'b1};
        tbl[2] = '{-1,  1'b0, 4'd1,  3,   3,   1'b0, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{98,  1'b0, 4'd5,  103, 103, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[4] = '{-1,  1'b1, 4'd5,  98,  98,  1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{995, 1'b0, 4'd9,  999, 4,   1'b1, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{2,   1'b1, 4'd7,  0,   995, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{0,   1'b0, 4'hC,  9,   9,   1'b0, 1'b0, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", {rdy_s, rdy_w}, 2'b11);
        check("reset_new_high", {nh_s, nh_w}, 2'b00);
        check_state("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            if (tbl[i].pre >= 0) preset(tbl[i].pre);
            do_op(tbl[i].sub, tbl[i].d, 1'b0, a, b);
            check($sformatf("tbl%0d_score_sat", i),  32'(sc_s), 32'(int2bcd(tbl[i].exp_s)));
            check($sformatf("tbl%0d_score_wrap", i), 32'(sc_w), 32'(int2bcd(tbl[i].exp_w)));
            check($sformatf("tbl%0d_ovf", i), {ovf_s, ovf_w}, {tbl[i].ov_s, tbl[i].ov_w});
            check($sformatf("tbl%0d_new_high", i), {a, b}, {tbl[i].nh_s, tbl[i].nh_w});
        end

        // Clear during DIGIT aborts the op: no commit, high untouched.
        preset(10);
        @(negedge clk);
        op_valid = 1'b1; op_sub = 1'b0; op_delta = 4'd3;
        @(posedge clk);
        #1 op_valid = 1'b0;
        @(negedge clk);
        clear = 1'b1;
        #1 check("ready_mid_clear", {rdy_s, rdy_w}, 2'b00);
        @(posedge clk);
        #1 clear = 1'b0;
        m_sc = '{0, 0}; m_ov = '{1'b0, 1'b0};
        @(negedge clk);
        check("ready_after_clear", {rdy_s, rdy_w}, 2'b11);
        check_state("midclear");
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (sc_s !== '0 || sc_w !== '0 || nh_s || nh_w) bad = 1'b1;
        end
        check("no_commit_after_clear", 32'(bad), 32'd0);

        // Overflow then clear + clear_high together.
        preset(995);
        do_op(1'b0, 4'd9, 1'b0, a, b);
        check("ovf_set", {ovf_s, ovf_w}, 2'b11);
        do_clear(1'b1, 1'b1);
        check("both_clear", {20'd0, sc_s | sc_w | hi_s | hi_w}, 32'd0);

        // clear_high coinciding with commit suppresses the new high.
        do_op(1'b0, 4'd5, 1'b1, a, b);
        check("ch_commit_no_nh", {a, b}, 2'b00);
        do_op(1'b0, 4'd0, 1'b0, a, b);
        check("zero_delta_new_high", {a, b}, 2'b11);

        for (int i = 0; i < 60; i++) begin
            if (i == 30) preset(985);
            case ($urandom_range(0, 9))
                0: do_clear(1'b0, 1'b1);
                1: do_clear(1'b1, 1'b0);
                default: ;
            endcase
            do_op($urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 15) == 0, a, b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
